// File: rtl/video_bank_ctrl.sv
// Double-buffered 1-bpp frame store: one bank fills from the source while the other streams to VGA.
// Define VIDEO_BANK_REPEAT_CNT_EN to build the saturating repeat_count; otherwise it is tied to 0.
module video_bank_ctrl #(
    parameter int H_AREA = 800,
    parameter int V_AREA = 600,
    parameter int WORD_W = 16,
    parameter int DEPTH  = H_AREA * V_AREA / WORD_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              CLK_40,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              ACTIVE,
    output logic              pixel_color,
    output logic              read_bank1,
    output logic              read_bank2,
    output logic              frame_done,
    output logic              frame_repeat,
    output logic [15:0]       repeat_count
);

    localparam int TOTAL = H_AREA * V_AREA;
    localparam int PW    = $clog2(TOTAL);
    localparam int BW    = $clog2(WORD_W);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PIX  = PW'(TOTAL - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);

    typedef enum logic {W_FILL, W_FULL} wr_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_SCAN, R_BOUND, R_LOAD} rd_state_t;

    wr_state_t wr_state, wr_state_nx;
    rd_state_t rd_state, rd_state_nx;

    logic [WORD_W-1:0] bank1_mem [DEPTH];
    logic [WORD_W-1:0] bank2_mem [DEPTH];

    logic              wr_bank;          // 0 selects bank 1, 1 selects bank 2
    logic [AW-1:0]     wr_addr;
    logic              wr_fire;
    logic              wr_last;
    logic              wr_full_nx;
    logic              swap;

    logic              rd_en;
    logic              rd_bank;
    logic [AW-1:0]     rd_sel_addr;
    logic [AW-1:0]     rd_addr;
    logic              rd_done;
    logic [WORD_W-1:0] pf_word;
    logic              pf_valid;

    logic [WORD_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [PW-1:0]     pix_cnt;
    logic              held_pix;
    logic              consume;
    logic              load_word0;

    // ---------------- write side ----------------
    assign wr_fire    = wr_valid && wr_ready;
    assign wr_last    = wr_fire && (wr_addr == LAST_ADDR);
    // A bank completing on the same edge as the last pixel still counts as ready.
    assign wr_full_nx = (wr_state == W_FULL) || wr_last;

    always_comb begin
        wr_state_nx = wr_state;
        case (wr_state)
            W_FILL:  if (wr_last) wr_state_nx = W_FULL;
            W_FULL:  if (swap) wr_state_nx = W_FILL;
            default: wr_state_nx = W_FILL;
        endcase
    end

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            wr_state <= W_FILL;
            wr_ready <= 1'b0;
            wr_bank  <= 1'b0;
            wr_addr  <= '0;
        end else begin
            wr_state <= wr_state_nx;
            wr_ready <= (wr_state_nx == W_FILL);
            if (swap) begin
                wr_bank <= ~wr_bank;
                wr_addr <= '0;
            end else if (wr_fire) begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    // Bank storage with one registered read port feeding the prefetch word.
    always_ff @(posedge CLK_40) begin
        if (wr_fire) begin
            if (wr_bank) bank2_mem[wr_addr] <= wr_data;
            else         bank1_mem[wr_addr] <= wr_data;
        end
        if (rd_en) pf_word <= rd_bank ? bank2_mem[rd_sel_addr] : bank1_mem[rd_sel_addr];
    end

    // ---------------- read side ----------------
    always_comb begin
        rd_state_nx = rd_state;
        swap        = 1'b0;
        rd_en       = 1'b0;
        rd_bank     = read_bank2;
        rd_sel_addr = rd_addr;
        consume     = 1'b0;
        load_word0  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (wr_state == W_FULL) begin
                    rd_en       = 1'b1;
                    rd_bank     = wr_bank;
                    rd_sel_addr = '0;
                    rd_state_nx = R_START;
                end
            end
            R_START: begin
                swap        = 1'b1;
                load_word0  = 1'b1;
                rd_state_nx = R_SCAN;
            end
            R_SCAN: begin
                consume = ACTIVE;
                rd_en   = !pf_valid && !rd_done;
                if (ACTIVE && (pix_cnt == LAST_PIX)) rd_state_nx = R_BOUND;
            end
            R_BOUND: begin
                // Swap if the next frame is ready, otherwise re-read the shown bank.
                swap        = (wr_state == W_FULL);
                rd_en       = 1'b1;
                rd_bank     = swap ? wr_bank : read_bank2;
                rd_sel_addr = '0;
                rd_state_nx = R_LOAD;
            end
            R_LOAD: begin
                load_word0  = 1'b1;
                rd_state_nx = R_SCAN;
            end
            default: rd_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            rd_state     <= R_IDLE;
            read_bank1   <= 1'b0;
            read_bank2   <= 1'b0;
            rd_addr      <= '0;
            rd_done      <= 1'b0;
            pf_valid     <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            held_pix     <= 1'b0;
            frame_done   <= 1'b0;
            frame_repeat <= 1'b0;
        end else begin
            rd_state     <= rd_state_nx;
            held_pix     <= pixel_color;
            frame_done   <= 1'b0;
            frame_repeat <= 1'b0;
            if (swap) begin
                read_bank1 <= ~wr_bank;
                read_bank2 <= wr_bank;
            end
            if (load_word0) begin
                shreg    <= pf_word;
                bit_cnt  <= LAST_BIT;
                pix_cnt  <= '0;
                pf_valid <= 1'b0;
                rd_addr  <= AW'(1);
                rd_done  <= (DEPTH == 1);
            end else if (rd_state == R_SCAN) begin
                // WORD_W >= 2 leaves at least one cycle to refill the prefetch word.
                if (rd_en) begin
                    pf_valid <= 1'b1;
                    rd_addr  <= rd_addr + 1'b1;
                    rd_done  <= (rd_addr == LAST_ADDR);
                end
                if (consume) begin
                    if (bit_cnt == '0) begin
                        shreg    <= pf_word;
                        bit_cnt  <= LAST_BIT;
                        pf_valid <= 1'b0;
                    end else begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                    if (pix_cnt == LAST_PIX) begin
                        pix_cnt      <= '0;
                        frame_done   <= 1'b1;
                        frame_repeat <= !wr_full_nx;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Shown pixel is live while consuming and holds its last value otherwise.
    assign pixel_color = (ACTIVE && (rd_state == R_SCAN)) ? shreg[WORD_W-1] : held_pix;

`ifdef VIDEO_BANK_REPEAT_CNT_EN
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            repeat_count <= '0;
        end else if (frame_repeat && (repeat_count != 16'hFFFF)) begin
            repeat_count <= repeat_count + 16'd1;
        end
    end
`else
    assign repeat_count = '0;
`endif

endmodule

// File: tb/tb_video_bank_ctrl.sv
// Self-checking bench for video_bank_ctrl with an 8x4 frame of 4-bit words (8 words per bank).
module tb_video_bank_ctrl;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic [3:0]  wr_data;
    logic        wr_ready;
    logic        ACTIVE;
    logic        pixel_color;
    logic        read_bank1;
    logic        read_bank2;
    logic        frame_done;
    logic        frame_repeat;
    logic [15:0] repeat_count;

    int n_total = 0;
    int n_bad   = 0;

    logic [0:0] exp_q[$];
    logic [3:0] img[8];
    logic       mon_en   = 1'b0;
    logic       hold_chk = 1'b0;
    logic       last_pix = 1'b0;
    int         fd_cnt = 0, fr_cnt = 0, both_cnt = 0, orphan_cnt = 0, extra_cnt = 0;
    logic [15:0] exp_rc;

    video_bank_ctrl #(.H_AREA(8), .V_AREA(4), .WORD_W(4)) dut (
        .CLK_40      (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .ACTIVE      (ACTIVE),
        .pixel_color (pixel_color),
        .read_bank1  (read_bank1),
        .read_bank2  (read_bank2),
        .frame_done  (frame_done),
        .frame_repeat(frame_repeat),
        .repeat_count(repeat_count)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // scoreboard / monitor on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) fd_cnt++;
            if (frame_repeat) fr_cnt++;
            if (read_bank1 && read_bank2) both_cnt++;
            if (frame_repeat && !frame_done) orphan_cnt++;
            if (mon_en && ACTIVE) begin
                if (exp_q.size() != 0) begin
                    logic [0:0] e;
                    e = exp_q.pop_front();
                    check_eq("pixel", {31'd0, pixel_color}, {31'd0, e});
                    last_pix = e;
                end else begin
                    extra_cnt++;
                end
            end else if (mon_en && hold_chk) begin
                check_eq("pixel_hold", {31'd0, pixel_color}, {31'd0, last_pix});
            end
        end
    end

    // driver tasks: all start and end 1 time unit after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        fd_cnt = 0;
        fr_cnt = 0;
        last_pix = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd0);
        check_eq({tag, "_pixel"}, {31'd0, pixel_color}, 32'd0);
        check_eq({tag, "_rb1"}, {31'd0, read_bank1}, 32'd0);
        check_eq({tag, "_rb2"}, {31'd0, read_bank2}, 32'd0);
        check_eq({tag, "_fdone"}, {31'd0, frame_done}, 32'd0);
        check_eq({tag, "_frep"}, {31'd0, frame_repeat}, 32'd0);
        check_eq({tag, "_rcount"}, {16'd0, repeat_count}, 32'd0);
    endtask

    task automatic do_reset();
        ACTIVE   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 4'h0;
        reset    = 1'b1;
        exp_q.delete();
        #1;
        check_reset_values("rst");
        idle(2);
        reset = 1'b0;
        clear_counts();
        check_eq("rst_release_ready", {31'd0, wr_ready}, 32'd0);
        idle(1);
        check_eq("rst_ready_rise", {31'd0, wr_ready}, 32'd1);
        mon_en = 1'b1;
    endtask

    // Leaves wr_valid high so back-to-back calls transfer every cycle.
    task automatic write_word(input logic [3:0] d);
        int guard;
        guard    = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && guard < 100) begin
            idle(1);
            guard++;
        end
        if (guard == 100) check_eq("wr_ready_timeout", {31'd0, wr_ready}, 32'd1);
        idle(1);
    endtask

    task automatic fill_img(input logic [3:0] d);
        for (int i = 0; i < 8; i++) img[i] = d;
    endtask

    task automatic write_img();
        for (int i = 0; i < 8; i++) write_word(img[i]);
        wr_valid = 1'b0;
    endtask

    task automatic push_img();
        for (int i = 0; i < 8; i++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(img[i][b]);
    endtask

    // n ACTIVE cycles; optional gaps (always 2 idle cycles at word boundaries);
    // optional write transfer on the edge that consumes the last pixel.
    task automatic scan(input int n, input bit gaps, input bit wr_last, input logic [3:0] wr_d);
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) begin
                int g;
                g = (k % 4 == 0) ? 2 : int'($urandom_range(0, 1));
                for (int j = 0; j < g; j++) begin
                    ACTIVE   = 1'b0;
                    hold_chk = 1'b1;
                    idle(1);
                end
            end
            ACTIVE   = 1'b1;
            hold_chk = 1'b0;
            if (wr_last && k == n - 1) begin
                wr_valid = 1'b1;
                wr_data  = wr_d;
            end
            idle(1);
        end
        ACTIVE   = 1'b0;
        hold_chk = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic frame(input bit gaps);
        push_img();
        scan(32, gaps, 1'b0, 4'h0);
        idle(6);
        check_eq("frame_q_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        ACTIVE = 1'b0;
        wr_valid = 1'b0;
        wr_data = 4'h0;

        // 1: first fill, start latency, first frame repeats
        do_reset();
        fill_img(4'hA);
        write_img();
        check_eq("s1_wr_ready_fall", {31'd0, wr_ready}, 32'd0);
        check_eq("s1_rb1_lat0", {31'd0, read_bank1}, 32'd0);
        idle(1);
        check_eq("s1_rb1_lat1", {31'd0, read_bank1}, 32'd0);
        idle(1);
        check_eq("s1_rb1_lat2", {31'd0, read_bank1}, 32'd1);
        check_eq("s1_rb2", {31'd0, read_bank2}, 32'd0);
        check_eq("s1_wr_ready_back", {31'd0, wr_ready}, 32'd1);
        frame(1'b0);
        check_eq("s1_fdone_cnt", fd_cnt, 32'd1);
        check_eq("s1_frep_cnt", fr_cnt, 32'd1);
        check_eq("s1_rb1_kept", {31'd0, read_bank1}, 32'd1);

        // 2: swap at frame boundary
        do_reset();
        fill_img(4'hF);
        write_img();
        idle(2);
        fill_img(4'h0);
        write_img();
        check_eq("s2_wr_full", {31'd0, wr_ready}, 32'd0);
        fill_img(4'hF);
        frame(1'b0);
        check_eq("s2_fdone_cnt", fd_cnt, 32'd1);
        check_eq("s2_frep_cnt", fr_cnt, 32'd0);
        check_eq("s2_rb1_off", {31'd0, read_bank1}, 32'd0);
        check_eq("s2_rb2_on", {31'd0, read_bank2}, 32'd1);
        check_eq("s2_wr_ready_reassert", {31'd0, wr_ready}, 32'd1);
        fill_img(4'h0);
        frame(1'b0);
        check_eq("s2_fdone_cnt2", fd_cnt, 32'd2);
        check_eq("s2_frep_cnt2", fr_cnt, 32'd1);

        // 3: bank completes on the same edge as the last pixel
        do_reset();
        fill_img(4'h5);
        write_img();
        idle(2);
        for (int i = 0; i < 7; i++) write_word(4'h9);
        wr_valid = 1'b0;
        push_img();
        scan(32, 1'b0, 1'b1, 4'h9);
        idle(6);
        check_eq("s3_q_empty", exp_q.size(), 32'd0);
        check_eq("s3_frep_cnt", fr_cnt, 32'd0);
        check_eq("s3_rb2_on", {31'd0, read_bank2}, 32'd1);
        check_eq("s3_rb1_off", {31'd0, read_bank1}, 32'd0);
        fill_img(4'h9);
        frame(1'b0);
        check_eq("s3_frep_cnt2", fr_cnt, 32'd1);

        // 4: ACTIVE gaps across word boundaries, random content, repeated twice
        do_reset();
        for (int i = 0; i < 8; i++) img[i] = 4'($urandom_range(0, 15));
        write_img();
        idle(2);
        frame(1'b1);
        frame(1'b1);
        check_eq("s4_fdone_cnt", fd_cnt, 32'd2);
        check_eq("s4_frep_cnt", fr_cnt, 32'd2);

        // 5: reset in the middle of frame 2 with a partial fill pending
        do_reset();
        fill_img(4'hC);
        write_img();
        idle(2);
        frame(1'b0);
        for (int i = 0; i < 3; i++) write_word(4'h3);
        wr_valid = 1'b0;
        push_img();
        scan(16, 1'b0, 1'b0, 4'h0);
        check_eq("s5_pre_rb1", {31'd0, read_bank1}, 32'd1);
        mon_en = 1'b0;
        ACTIVE = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("s5_mid");
        ACTIVE = 1'b0;
        exp_q.delete();
        idle(1);
        reset = 1'b0;
        clear_counts();
        mon_en = 1'b1;
        idle(1);
        check_eq("s5_ready_rise", {31'd0, wr_ready}, 32'd1);
        fill_img(4'h6);
        for (int i = 0; i < 7; i++) write_word(img[i]);
        wr_valid = 1'b0;
        idle(3);
        check_eq("s5_no_disp_rb1", {31'd0, read_bank1}, 32'd0);
        check_eq("s5_no_disp_rb2", {31'd0, read_bank2}, 32'd0);
        write_word(img[7]);
        wr_valid = 1'b0;
        idle(2);
        check_eq("s5_rb1_on", {31'd0, read_bank1}, 32'd1);
        check_eq("s5_rb2_off", {31'd0, read_bank2}, 32'd0);
        frame(1'b0);
        check_eq("s5_fdone_cnt", fd_cnt, 32'd1);

        // 6: repeated frames and the optional counter
        do_reset();
        fill_img(4'h7);
        write_img();
        idle(2);
        for (int f = 0; f < 3; f++) frame(1'b0);
        check_eq("s6_frep_cnt", fr_cnt, 32'd3);
`ifdef VIDEO_BANK_REPEAT_CNT_EN
        exp_rc = 16'd3;
`else
        exp_rc = 16'd0;
`endif
        check_eq("s6_repeat_count", {16'd0, repeat_count}, {16'd0, exp_rc});

        // final report
        check_eq("both_banks_seen", both_cnt, 32'd0);
        check_eq("repeat_without_done", orphan_cnt, 32'd0);
        check_eq("unexpected_pixels", extra_cnt, 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/video_bank_ctrl.md
Name: video_bank_ctrl

Overview:
- Double-buffered 1-bpp frame store that sits directly upstream of the VGA output stage.
- A frame source writes packed pixel words into one bank while the other bank is scanned out, one bit per active pixel.
- The block drives pixel_color, read_bank1 and read_bank2 to the VGA stage and consumes its ACTIVE strobe.
- Banks swap only on frame boundaries. If the next frame is not ready at a boundary, the displayed frame is repeated.

Parameters:
- H_AREA, 800, active pixels per line
- V_AREA, 600, active lines per frame
- WORD_W, 16, pixels per write word, MSB displayed first; H_AREA*V_AREA must be divisible by WORD_W, and WORD_W >= 2
- DEPTH, H_AREA*V_AREA/WORD_W, words per bank (derived; do not override)
- AW, $clog2(DEPTH), word address width (derived)

Ports:
- CLK_40  in  1  pixel clock, the only clock
- reset  in  1  asynchronous, active-high
- wr_valid  in  1  source presents a word
- wr_data  in  WORD_W  packed pixels, MSB = leftmost pixel
- wr_ready  out  1  block accepts the word this cycle
- ACTIVE  in  1  VGA stage is in the visible area; consume one pixel per cycle
- pixel_color  out  1  current pixel, valid in every cycle ACTIVE=1
- read_bank1  out  1  bank 1 is being displayed
- read_bank2  out  1  bank 2 is being displayed
- frame_done  out  1  1-cycle pulse after the last pixel of a frame is consumed
- frame_repeat  out  1  1-cycle pulse, coincident with frame_done, when no new frame was ready
- repeat_count  out  16  repeated-frame counter (see Optional Feature)

Behaviour:
- Reset values: wr_ready=0, pixel_color=0, read_bank1=0, read_bank2=0, frame_done=0, frame_repeat=0, repeat_count=0. Write bank = bank 1, write state = FILL.
- Wr_ready deasserts on the same cycle reset asserts and rises on the first clock edge after reset releases.
- Reset asserted mid-frame or mid-fill discards all bank contents and state; memory contents need not be cleared.
- Write handshake: a word is transferred when wr_valid && wr_ready at the clock edge. wr_ready is registered and does not depend on wr_valid. Words are written to the write bank at address wr_addr, which increments by 1 per transfer.
- Write FSM:
  - FILL: wr_ready=1. The transfer at wr_addr=DEPTH-1 completes the bank; go to FULL with wr_ready=0.
  - FULL: wr_ready=0. Hold until the bank is handed to the display (swap), then set wr_addr=0, write bank = the other bank, and return to FILL.
- Display start (no bank displayed):
  - When the write bank becomes FULL, its word 0 is loaded into the output shift register.
  - The matching read_bankN asserts 2 cycles after the completing write transfer, and the swap occurs.
  - ACTIVE is ignored while read_bank1=read_bank2=0; pixel_color stays 0.
- Scan-out, while read_bankN=1:
  - Each cycle with ACTIVE=1: pixel_color = current word bit (MSB first), and the bit index advances.
  - After bit 0 of a word is used, the next word (prefetched from memory) is loaded with no bubble. Consecutive ACTIVE cycles across word and line boundaries must stream without gaps.
  - pixel_color is held while ACTIVE=0; the VGA stage blanks it.
  - A pixel counter counts consumed pixels. On consuming pixel H_AREA*V_AREA-1, frame_done pulses on the next cycle and the frame boundary occurs.
- At a frame boundary:
  - If the write bank is FULL, swap: read_bank1/read_bank2 toggle together, so exactly one is 1.
  - Otherwise, re-display the same bank and pulse frame_repeat.
  - In both cases reset the read address and bit index, and preload word 0 within 2 cycles. The VGA stage guarantees at least 4 ACTIVE=0 cycles between frames.
- Simultaneous events: a write transfer that completes the bank in the same cycle as the last pixel is consumed counts as FULL, so the swap happens with no repeat.
- Invariant: read_bank1 && read_bank2 is never 1. Once a bank is displayed, one of the two stays 1 until reset.

Optional Feature:
- Macro: VIDEO_BANK_REPEAT_CNT_EN.
- Defined: repeat_count increments on each frame_repeat pulse, saturates at 16'hFFFF and clears only on reset.
- Undefined: no counter logic; repeat_count is tied to 0. frame_repeat is present in both builds.

Test Plan:
- Bench parameters: H_AREA=8, V_AREA=4, WORD_W=4, so DEPTH=8.
- Scenarios:
  1. Reset, then write 8 words 4'hA with wr_valid held 1 -> wr_ready falls after the 8th transfer; read_bank1=1 two cycles later; a 32-cycle ACTIVE burst yields pixel_color 1,0,1,0... continuously; frame_done pulses once; frame_repeat pulses, since bank 2 is empty.
  2. Fill bank 1 with 4'hF and bank 2 with 4'h0, then scan a frame -> at frame_done, read_bank1 goes 1->0 and read_bank2 goes 0->1; the next frame's pixel_color is all 0; wr_ready re-asserts after the swap.
  3. Complete bank 2's 8th write in the same cycle the 32nd pixel is consumed -> swap, frame_repeat stays 0.
  4. ACTIVE toggling 1,0,0,1 across a word boundary -> pixel sequence is unchanged versus a continuous burst, with no skipped or duplicated pixel.
  5. Assert reset midway through frame 2 with 3 words written to the write bank -> all outputs return to reset values immediately; after release, 8 new words are required before read_bank1 asserts.
  6. With VIDEO_BANK_REPEAT_CNT_EN defined, display 3 frames with no new writes -> repeat_count = 3; undefined -> repeat_count stays 0.
